// File: rtl/tk1_spi_target_if.sv
// tk1_spi_target_if: SPI pins plus byte-level tx/rx/status handshake of the SPI target.
interface tk1_spi_target_if;
    logic       spi_ss;
    logic       spi_sck;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic [7:0] tx_data;
    logic       tx_data_vld;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_data_vld;
    logic       rx_ack;
    logic       selected;
    logic       rx_overrun;
    logic       tx_underrun;
    logic       status_clr;

    modport slave (
        input  spi_ss, spi_sck, spi_mosi, tx_data, tx_data_vld, rx_ack, status_clr,
        output spi_miso, spi_miso_oe, tx_ready, rx_data, rx_data_vld, selected,
               rx_overrun, tx_underrun
    );

    modport master (
        output spi_ss, spi_sck, spi_mosi, tx_data, tx_data_vld, rx_ack, status_clr,
        input  spi_miso, spi_miso_oe, tx_ready, rx_data, rx_data_vld, selected,
               rx_overrun, tx_underrun
    );
endinterface

// File: rtl/tk1_spi_target.sv
// tk1_spi_target: SPI mode 0 target, oversampled in clk, with one-deep tx buffer,
// held rx register and sticky overrun/underrun flags.
module tk1_spi_target #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = 8'hff
) (
    input logic               clk,
    input logic               reset_n,
    tk1_spi_target_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, BYTE_DONE, WAIT_FALL} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] ss_q, sck_q, mosi_q;
    logic                   sck_prev_q;
    logic [2:0]             bit_ctr_q, bit_ctr_d;
    logic [7:0]             shift_rx_q, shift_rx_d, shift_tx_q, shift_tx_d;
    logic [7:0]             txbuf_q, txbuf_d, rx_data_q, rx_data_d;
    logic                   txbuf_full_q, txbuf_full_d, rx_vld_q, rx_vld_d;
    logic                   ovr_q, ovr_d, udr_q, udr_d;

    logic ss_s, sck_s, mosi_s, sck_rise, sck_fall, active, load, store, wr, shift_rise;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            ss_q       <= '1;
            sck_q      <= '0;
            mosi_q     <= '0;
            sck_prev_q <= 1'b0;
        end else begin
            ss_q       <= {ss_q[SYNC_STAGES-2:0], bus.spi_ss};
            sck_q      <= {sck_q[SYNC_STAGES-2:0], bus.spi_sck};
            mosi_q     <= {mosi_q[SYNC_STAGES-2:0], bus.spi_mosi};
            sck_prev_q <= sck_q[SYNC_STAGES-1];
        end

    assign ss_s       = ss_q[SYNC_STAGES-1];
    assign sck_s      = sck_q[SYNC_STAGES-1];
    assign mosi_s     = mosi_q[SYNC_STAGES-1];
    assign sck_rise   = sck_s & ~sck_prev_q;
    assign sck_fall   = ~sck_s & sck_prev_q;
    assign active     = (state_q != IDLE) && !ss_s;
    // a byte boundary reload happens on entry (LOAD) and on the fall that ends each byte
    assign load       = active && (state_q == LOAD || (state_q == WAIT_FALL && sck_fall));
    assign store      = active && state_q == BYTE_DONE && (!rx_vld_q || bus.rx_ack);
    assign wr         = bus.tx_data_vld && !txbuf_full_q;
    assign shift_rise = active && state_q == SHIFT && sck_rise;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;

    always_comb begin
        state_d = state_q;
        if (state_q != IDLE && ss_s) state_d = IDLE;
        else
            case (state_q)
                IDLE:      state_d = ss_s ? IDLE : LOAD;
                LOAD:      state_d = SHIFT;
                SHIFT:     state_d = (sck_rise && bit_ctr_q == 3'd7) ? BYTE_DONE : SHIFT;
                BYTE_DONE: state_d = WAIT_FALL;
                WAIT_FALL: state_d = sck_fall ? SHIFT : WAIT_FALL;
                default:   state_d = IDLE;
            endcase
    end

    always_comb begin
        bus.spi_miso_oe = state_q != IDLE;
        bus.spi_miso    = (state_q != IDLE) & shift_tx_q[7];
    end

    always_comb begin
        bit_ctr_d    = (!active || load) ? 3'd0 : shift_rise ? bit_ctr_q + 3'd1 : bit_ctr_q;
        shift_rx_d   = shift_rise ? {shift_rx_q[6:0], mosi_s} : shift_rx_q;
        shift_tx_d   = load ? (txbuf_full_q ? txbuf_q : IDLE_BYTE) :
                       (active && state_q == SHIFT && sck_fall && bit_ctr_q != 3'd0) ?
                       {shift_tx_q[6:0], 1'b0} : shift_tx_q;
        txbuf_d      = wr ? bus.tx_data : txbuf_q;
        txbuf_full_d = wr || (txbuf_full_q && !load);
        rx_data_d    = store ? shift_rx_q : rx_data_q;
        rx_vld_d     = store || (rx_vld_q && !bus.rx_ack);
        ovr_d        = !bus.status_clr &&
                       (ovr_q || (active && state_q == BYTE_DONE && rx_vld_q && !bus.rx_ack));
        udr_d        = !bus.status_clr && (udr_q || (load && !txbuf_full_q));
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            bit_ctr_q    <= '0;
            shift_rx_q   <= '0;
            shift_tx_q   <= '0;
            txbuf_q      <= '0;
            txbuf_full_q <= 1'b0;
            rx_data_q    <= '0;
            rx_vld_q     <= 1'b0;
            ovr_q        <= 1'b0;
            udr_q        <= 1'b0;
        end else begin
            bit_ctr_q    <= bit_ctr_d;
            shift_rx_q   <= shift_rx_d;
            shift_tx_q   <= shift_tx_d;
            txbuf_q      <= txbuf_d;
            txbuf_full_q <= txbuf_full_d;
            rx_data_q    <= rx_data_d;
            rx_vld_q     <= rx_vld_d;
            ovr_q        <= ovr_d;
            udr_q        <= udr_d;
        end

    assign bus.tx_ready    = ~txbuf_full_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_data_vld = rx_vld_q;
    assign bus.selected    = ~ss_s;
    assign bus.rx_overrun  = ovr_q;
    assign bus.tx_underrun = udr_q;
endmodule
